// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data_mem block.
`timescale 1ns/1ps
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int MEM_WORD_BYTES = 4;

endpackage

// File: rtl/data_mem_mem_array.sv
// Byte-enabled DEPTH_WORDS x 32 storage: synchronous write, combinational read.
`timescale 1ns/1ps
module mem_array
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                      i_clk,
  input  logic                      i_we,
  input  logic [AW-1:0]             i_idx,
  input  logic [31:0]               i_wdata,
  input  logic [MEM_WORD_BYTES-1:0] i_wstrb,
  output logic [31:0]               o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < MEM_WORD_BYTES; b++) begin
        if (i_wstrb[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_mem.sv
// Single-port data memory with fixed response latency and valid/ready handshakes.
// Optional build macro DATA_MEM_MISALIGN_CHECK_EN faults accesses with addr[1:0] != 0.
`timescale 1ns/1ps
module data_mem
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mem_state_t  r_state;
  mem_state_t  w_next;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic        r_error;

  logic        w_accept;
  logic        w_enter_resp;
  logic        w_acc_write;
  logic [31:0] w_acc_addr;
  logic [31:0] w_acc_wdata;
  logic [3:0]  w_acc_wstrb;
  logic        w_oob;
  logic        w_misalign;
  logic        w_err;
  logic        w_we;
  logic [31:0] w_mem_rdata;

  assign w_accept = req_valid && (r_state == IDLE);

  // With zero wait cycles the access happens on the accepting edge, so use the live request.
  assign w_acc_write = (r_state == IDLE) ? req_write : r_write;
  assign w_acc_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_acc_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_acc_wstrb = (r_state == IDLE) ? req_wstrb : r_wstrb;

  assign w_oob = (w_acc_addr >> (AW + 2)) != 32'd0;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
  assign w_misalign = |w_acc_addr[1:0];
`else
  assign w_misalign = 1'b0;
`endif
  assign w_err = w_oob || w_misalign;

  assign w_enter_resp = (w_next == RESP) && (r_state != RESP);
  assign w_we         = w_enter_resp && w_acc_write && !w_err && rst_n;

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem_array (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_idx   (w_acc_addr[AW+1:2]),
    .i_wdata (w_acc_wdata),
    .i_wstrb (w_acc_wstrb),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (r_cnt == 4'd0) w_next = RESP;
      RESP: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == IDLE);
    rsp_valid = (r_state == RESP);
    rsp_rdata = r_rdata;
    rsp_error = r_error;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_error <= 1'b0;
    end else begin
      if (w_accept) r_cnt <= CNT_INIT;
      else if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_enter_resp) begin
        r_error <= w_err;
        r_rdata <= (w_err || w_acc_write) ? 32'd0 : w_mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_wstrb <= req_wstrb;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed scenarios plus randomized traffic against a word-array model.
`timescale 1ns/1ps
module tb_data_mem;

  localparam int DEPTH = 256;
  localparam int WAITC = 2;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  data_mem #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WAITC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: memory is a plain word array indexed by byte address / 4.
  task automatic model_access(input bit w, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] st, output logic [31:0] rd, output logic er);
    int idx;
    er = (a >= 32'(4 * DEPTH)) || (MIS_EN && (a % 4 != 0));
    rd = 32'd0;
    if (!er) begin
      idx = int'(a / 4);
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (st[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        rd = model[idx];
      end
    end
  endtask

  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input int hold, input string tag);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          n;
    model_access(w, a, wd, st, exp_rd, exp_er);
    @(negedge clk);
    chk({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_wstrb = st;
    rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ":latency"}, 32'(n), 32'(WAITC + 1));
    chk({tag, ":rdata"}, rsp_rdata, exp_rd);
    chk({tag, ":error"}, 32'(rsp_error), 32'(exp_er));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = $urandom; req_wstrb = 4'hF;
      @(negedge clk);
      chk({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ":hold_rdata"}, rsp_rdata, exp_rd);
      chk({tag, ":hold_error"}, 32'(rsp_error), 32'(exp_er));
      chk({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
    end
    // A stray request held across the completing edge must not be taken.
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = $urandom; req_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk({tag, ":done_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ":done_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    int r;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_wstrb = 4'h0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst:req_ready", 32'(req_ready), 32'd1);
    chk("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst:rsp_rdata", rsp_rdata, 32'd0);
    chk("rst:rsp_error", 32'(rsp_error), 32'd0);

    for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0, "preload");

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "st10");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, "ld10");
    txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0, "pre20");
    txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, "strb20");
    txn(1'b0, 32'h20, 32'h0, 4'h0, 0, "ld20");
    txn(1'b1, 32'h24, 32'h12345678, 4'h0, 0, "strb0");
    txn(1'b0, 32'h24, 32'h0, 4'h0, 0, "ld24");
    txn(1'b0, 32'h400, 32'h0, 4'h0, 0, "ld400");
    txn(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, "st400");
    txn(1'b1, 32'hFFFF_FFFC, 32'hFFFFFFFF, 4'hF, 1, "sthigh");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 5, "ldhold5");
    txn(1'b0, 32'h0A, 32'h0, 4'h0, 0, "ld0a");
    txn(1'b1, 32'h0E, 32'hCAFEF00D, 4'hF, 0, "st0e");
    txn(1'b0, 32'h0C, 32'h0, 4'h0, 0, "ld0c");

    // Reset while a store sits in WAIT: it must be dropped.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h08; req_wdata = 32'h55; req_wstrb = 4'hF;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstwait:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstwait:req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("rstwait:rsp_rdata", rsp_rdata, 32'd0);
    chk("rstwait:rsp_error", 32'(rsp_error), 32'd0);
    rst_n = 1'b1;
    rsp_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rstwait:no_rsp", 32'(rsp_valid), 32'd0);
    end
    txn(1'b0, 32'h08, 32'h0, 4'h0, 0, "ld08_after_rst");

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
      else             a = 32'($urandom_range(0, 4 * DEPTH - 1));
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 2), "rand");
    end

    for (int i = 0; i < DEPTH; i++) txn(1'b0, 32'(i * 4), 32'h0, 4'h0, 0, "sweep");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two, >=4).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra cycles between request acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request can be accepted.
REQ-007 SHALL have port req_write  input  1  1=store, 0=load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_wstrb  input  4  byte-lane enables; bit i selects byte i.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-013 SHALL have port rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_error  output  1  access faulted; no memory update.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-017 SHALL accept a request on a rising edge with req_valid && req_ready, latching write, addr, wdata, wstrb.
REQ-018 SHALL, on acceptance, go to WAIT with counter=WAIT_CYCLES-1 when WAIT_CYCLES>0, else directly to RESP.
REQ-019 SHALL decrement the counter each WAIT cycle and go to RESP on the edge where counter==0.
REQ-020 SHALL make rsp_valid rise exactly WAIT_CYCLES+1 edges after the accepting edge.
REQ-021 SHALL commit a store and capture load data on the edge entering RESP, not earlier.
REQ-022 SHALL write only byte lanes with wstrb set; wstrb=0 is a legal no-op store with rsp_error=0.
REQ-023 SHALL use word index req_addr[log2(DEPTH_WORDS)+1:2]; any address >= 4*DEPTH_WORDS SHALL set rsp_error=1.
REQ-024 SHALL hold rsp_valid, rsp_rdata, rsp_error stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-025 SHALL NOT accept a new request in the cycle a response completes; earliest acceptance is the following cycle.
REQ-026 SHALL ignore req_* while not in IDLE.

Reset
REQ-027 SHALL, on rst_n low at any time, force IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, req_ready=1 after release.
REQ-028 SHALL abandon an in-flight request on reset; a store not yet committed SHALL NOT reach the array.
REQ-029 SHALL NOT reset memory array contents.

Configuration
REQ-030 With DATA_MEM_MISALIGN_CHECK_EN defined, a request with req_addr[1:0]!=0 SHALL complete with rsp_error=1, rsp_rdata=0, no write, same latency.
REQ-031 Without DATA_MEM_MISALIGN_CHECK_EN, req_addr[1:0] SHALL be ignored and the aligned word accessed.

Structure
REQ-032 SHALL place typedef mem_state_t (IDLE/WAIT/RESP) and constant MEM_WORD_BYTES=4 in pkg.
REQ-033 SHALL instantiate one sub-module mem_array: synchronous-write, byte-enabled DEPTH_WORDS x 32 storage.

Verification
REQ-034 Store addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_error=0, rsp_valid 3 edges after each accept (WAIT_CYCLES=2).
REQ-035 Preload 0x11223344 at 0x20, store wdata 0xAABBCCDD wstrb 4'b0101, load -> 0x11BB33DD.
REQ-036 Load addr 0x400 with DEPTH_WORDS=256 -> rsp_error=1, rsp_rdata=0; no word changes.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable, req_ready=0 throughout; new req accepted only the cycle after rsp_ready=1.
REQ-038 Assert rst_n=0 during WAIT of store 0x55 to 0x08 -> rsp_valid=0, later load of 0x08 returns prior contents.
REQ-039 With DATA_MEM_MISALIGN_CHECK_EN, load 0x0A -> rsp_error=1; without it, same load returns word at 0x08.
